// File: rtl/counter_pkg.sv
// Shared mode encodings for the multimode counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_MODULO  = 2'b01,
        MODE_SAT     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable divider: asserts tick on the enabled cycle where the count reaches prescale.
module tick_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    localparam logic [PRE_W-1:0] ONE = PRE_W'(1);

    logic [PRE_W-1:0] cnt;

    assign tick = en && (cnt == prescale);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == prescale) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/counter_multimode.sv
// Up/down counter with load, prescaler and FREE/MODULO/SATURATE/ONESHOT wrap modes.
module counter_multimode
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             at_limit,
    output logic             running
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX = '1;

    mode_t            mode_sel;
    logic             tick;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             run_nxt;

    assign mode_sel = mode_t'(mode);
    assign inc      = counter + ONE;
    assign dec      = counter - ONE;
    assign at_limit = (counter == limit);

    // A halted one-shot also freezes the prescaler so a reload restarts cleanly.
    tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clock    (clock),
        .rst      (rst),
        .en       (en && running),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        cnt_nxt = counter;
        tc_nxt  = 1'b0;
        run_nxt = running;
        if (load) begin
            cnt_nxt = load_val;
            run_nxt = 1'b1;
        end else if (tick) begin
            if (dir) begin
                case (mode_sel)
                    MODE_FREE: begin
                        cnt_nxt = inc;
                        tc_nxt  = (counter == MAX);
                    end
                    MODE_MODULO, MODE_ONESHOT: begin
                        // >= rather than == so a load above limit still wraps
                        if (counter >= limit) begin
                            cnt_nxt = '0;
                            tc_nxt  = 1'b1;
                            run_nxt = (mode_sel != MODE_ONESHOT);
                        end else begin
                            cnt_nxt = inc;
                        end
                    end
                    MODE_SAT: begin
                        if (counter < limit) begin
                            cnt_nxt = inc;
                            tc_nxt  = (inc == limit);
                        end
                    end
                    default: cnt_nxt = counter;
                endcase
            end else begin
                case (mode_sel)
                    MODE_FREE: begin
                        cnt_nxt = dec;
                        tc_nxt  = (counter == '0);
                    end
                    MODE_MODULO: begin
                        cnt_nxt = (counter == '0) ? limit : dec;
                        tc_nxt  = (counter == '0);
                    end
                    MODE_SAT: begin
                        if (counter != '0) begin
                            cnt_nxt = dec;
                            tc_nxt  = (dec == '0);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (counter == '0) begin
                            tc_nxt  = 1'b1;
                            run_nxt = 1'b0;
                        end else begin
                            cnt_nxt = dec;
                        end
                    end
                    default: cnt_nxt = counter;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            counter <= '0;
            tc      <= 1'b0;
            running <= 1'b1;
        end else begin
            counter <= cnt_nxt;
            tc      <= tc_nxt;
            running <= run_nxt;
        end
    end

endmodule

// File: tb/tb_counter_multimode.sv
// Randomised and directed bench for counter_multimode against a behavioural model.
module tb_counter_multimode;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
    localparam int PMOD  = 1 << PRE_W;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic             en    = 1'b0;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             dir   = 1'b1;
    logic [1:0]       mode  = 2'b00;
    logic [WIDTH-1:0] limit = '0;
    logic [PRE_W-1:0] prescale = '0;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             at_limit;
    logic             running;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt, m_pre, m_run, m_tc;

    counter_multimode #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clock    (clock),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .limit    (limit),
        .prescale (prescale),
        .counter  (counter),
        .tc       (tc),
        .at_limit (at_limit),
        .running  (running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_run = 1; m_tc = 0;
    endtask

    // Terminal-step rules written straight from the mode table.
    task automatic model_step();
        int lim;
        lim = int'(limit);
        if (dir) begin
            case (mode)
                2'b00: begin m_tc = (m_cnt == MAXV); m_cnt = (m_cnt + 1) % (MAXV + 1); end
                2'b01, 2'b11: begin
                    if (m_cnt >= lim) begin
                        m_cnt = 0; m_tc = 1;
                        if (mode == 2'b11) m_run = 0;
                    end else m_cnt = m_cnt + 1;
                end
                default: begin
                    if (m_cnt < lim) begin m_cnt = m_cnt + 1; m_tc = (m_cnt == lim); end
                end
            endcase
        end else begin
            case (mode)
                2'b00: begin m_tc = (m_cnt == 0); m_cnt = (m_cnt + MAXV) % (MAXV + 1); end
                2'b01: begin
                    if (m_cnt == 0) begin m_cnt = lim; m_tc = 1; end
                    else m_cnt = m_cnt - 1;
                end
                2'b10: begin
                    if (m_cnt != 0) begin m_cnt = m_cnt - 1; m_tc = (m_cnt == 0); end
                end
                default: begin
                    if (m_cnt == 0) begin m_tc = 1; m_run = 0; end
                    else m_cnt = m_cnt - 1;
                end
            endcase
        end
    endtask

    task automatic model_edge();
        m_tc = 0;
        if (rst) model_reset();
        else if (load) begin
            m_cnt = int'(load_val); m_pre = 0; m_run = 1;
        end else if (en && m_run == 1) begin
            if (m_pre == int'(prescale)) begin
                m_pre = 0;
                model_step();
            end else m_pre = (m_pre + 1) % PMOD;
        end
    endtask

    task automatic compare();
        check("counter", 32'(counter), 32'(m_cnt));
        check("tc", 32'(tc), 32'(m_tc));
        check("running", 32'(running), 32'(m_run));
        check("at_limit", 32'(at_limit), 32'(m_cnt == int'(limit)));
    endtask

    // Called just after a falling edge; leaves the bench just after the next falling edge.
    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1 compare();
        @(negedge clock);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = WIDTH'(v);
        cyc();
        load = 1'b0;
    endtask

    // Asserts rst between edges and checks that outputs clear without a clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        compare();
        @(posedge clock);
        #1 compare();
        @(negedge clock);
        rst = 1'b0;
    endtask

    initial begin
        int wait_n;
        model_reset();
        @(posedge clock);
        #1 compare();
        @(negedge clock);
        rst = 1'b0;

        // Free run through a full wrap
        mode = 2'b00; dir = 1'b1; prescale = '0; en = 1'b1; limit = 8'd200;
        cycles(256);
        check("free_wrap_cnt", 32'(counter), 32'd0);
        check("free_wrap_tc", 32'(tc), 32'd1);
        cyc();
        check("free_tc_once", 32'(tc), 32'd0);

        // Modulo up then down
        mode = 2'b01; limit = 8'd5;
        do_load(0);
        cycles(6);
        check("mod_up_wrap", 32'(tc), 32'd1);
        cycles(2);
        dir = 1'b0;
        cycles(3);
        check("mod_dn_cnt", 32'(counter), 32'd5);
        check("mod_dn_tc", 32'(tc), 32'd1);

        // Saturate with load above limit, then below
        dir = 1'b1; mode = 2'b10; limit = 8'd10;
        do_load(12);
        cycles(4);
        check("sat_hold", 32'(counter), 32'd12);
        do_load(8);
        cycles(4);
        check("sat_top", 32'(counter), 32'd10);

        // One-shot termination and reload
        mode = 2'b11; limit = 8'd3;
        do_load(0);
        cycles(4);
        check("os_run", 32'(running), 32'd0);
        cycles(3);
        do_load(1);
        cycles(3);

        // Prescaler with enable gaps and a load colliding with a step
        mode = 2'b00; prescale = 4'd3;
        do_load(0);
        cycles(5);
        en = 1'b0; cycles(2); en = 1'b1;
        cycles(5);
        do_load(40);
        cycles(6);

        // Async reset in a one-shot with the prescaler part-way
        mode = 2'b11; limit = 8'd20;
        do_load(7);
        cycles(2);
        async_reset();
        wait_n = 0;
        while (counter == '0 && wait_n < 20) begin
            cyc();
            wait_n++;
        end
        check("rst_first_step", 32'(wait_n), 32'd4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                continue;
            end
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                mode     = 2'($urandom);
                dir      = 1'($urandom);
                limit    = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 12)) : WIDTH'($urandom);
                prescale = PRE_W'($urandom_range(0, 3));
            end
            cyc();
            load = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_multimode.md
# counter_multimode

Parametrised up/down counter with synchronous load, programmable prescaler, and four wrap modes: free-running, modulo, saturate, one-shot. It generalises the plain load/reset counter for timer, PWM-period and event-count uses. It emits a one-cycle terminal-count pulse and a limit flag for downstream control logic.

## Interface

Parameters:
- WIDTH, 8, counter and limit width (≥2)
- PRE_W, 4, prescaler width; divide ratio is prescale+1 (1..2^PRE_W)

Ports:
- clock  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; gates the prescaler and the counter
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value loaded when load=1
- dir  input  1  1 = count up, 0 = count down
- mode  input  2  00 FREE, 01 MODULO, 10 SATURATE, 11 ONESHOT
- limit  input  WIDTH  modulo/saturate/one-shot bound
- prescale  input  PRE_W  step every prescale+1 enabled cycles
- counter  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, 1 cycle)
- at_limit  output  1  combinational: counter == limit
- running  output  1  registered; 0 once ONESHOT has terminated

## Operation

- Priority per edge: rst > load > step > hold.
- rst: counter=0, tc=0, running=1, prescaler=0.
- load: counter=load_val, prescaler=0, running=1, tc=0. Load ignores en.
- step: occurs when en=1, running=1, and prescaler==prescale. The prescaler then returns to 0. Otherwise, while en=1 and running=1, the prescaler increments. With en=0 the prescaler holds.
- Step behaviour by mode, up (dir=1):
  - FREE: counter+1, wrapping 2^WIDTH-1→0. tc=1 on the wrap.
  - MODULO: if counter ≥ limit, go to 0 with tc=1; otherwise counter+1. This recovers from a load above limit.
  - SATURATE: if counter ≥ limit, hold with no tc. Otherwise counter+1, with tc=1 when the new value equals limit.
  - ONESHOT: same as MODULO, but the terminal step sets counter=0, tc=1 and running=0.
- Step behaviour by mode, down (dir=0):
  - FREE: counter-1, wrapping 0→2^WIDTH-1. tc=1 on the wrap.
  - MODULO: 0→limit with tc=1; otherwise counter-1.
  - SATURATE: at 0, hold; otherwise counter-1, with tc=1 when the new value is 0.
  - ONESHOT: 0→0 with tc=1 and running=0; otherwise counter-1.
- tc is 0 on every cycle without a terminal step.
- A dir, mode or limit change takes effect on the next step. No internal state is cleared.
- All arithmetic is modulo 2^WIDTH. Comparisons are unsigned.

## Timing

- Inputs are sampled on the rising edge of clock. counter, tc and running update on that same edge. tc is high during the cycle in which counter shows the post-terminal value.
- Step latency from en rising: prescale+1 cycles with the prescaler at 0.
- Load takes effect on the next edge. A load coincident with a step wins, and no tc is produced.
- rst is asynchronous at any time, including mid-prescale or mid-oneshot. Outputs return to reset values immediately. Release is synchronised by the system.
- at_limit is purely combinational from counter and limit. It has no register delay.

## Structure

- Shared package counter_pkg holds the mode encodings (MODE_FREE=2'b00, MODE_MODULO=2'b01, MODE_SAT=2'b10, MODE_ONESHOT=2'b11) and the mode type.
- Sub-module tick_prescaler holds the PRE_W counter. Its ports are clock, rst, en, clr, prescale and tick.
- The top holds the next-state function, the tc register and the running register.

## Test plan

- Reset and free-run: WIDTH=8, FREE, up, prescale=0, en=1 from reset. Counter reads 0,1,…,255,0. tc is high for exactly one cycle, when the counter shows 0 after 255.
- Modulo up/down: MODULO, limit=5, up. Sequence is 0..5,0 with tc at 0. Switch to dir=0 at counter=2: sequence 2,1,0,5 with tc at 5.
- Saturate with load above limit: SATURATE, limit=10, up, load_val=12. Counter holds 12 with tc never high. Load 8: counter 9,10,10…, with tc only at the 10.
- One-shot and reload: ONESHOT, limit=3, up. Sequence 0,1,2,3,0; running drops to 0 and the counter stays 0. Load 1: running=1 and the count resumes 2,3,0.
- Prescaler plus priority: prescale=3, en=1. Counter steps every 4 cycles. en=0 for 2 cycles stretches the step by 2. Load with a coincident step: the load wins and the prescaler restarts at 0.
- Async reset mid-operation: assert rst between edges at counter=7 in ONESHOT with the prescaler at 2. counter=0, tc=0 and running=1 immediately. After release, the first step comes prescale+1 cycles later.
